// File: rtl/video_pattern_gen_if.sv
// Scan-coordinate / pixel bus between the HDMI encoder (master) and the pattern source (slave).
interface video_pattern_gen_if #(
  parameter int BIT_WIDTH = 11
);
  logic [BIT_WIDTH-1:0] cx;
  logic [BIT_WIDTH-1:0] cy;
  logic [23:0]          rgb;

  modport master (output cx, output cy, input rgb);
  modport slave  (input cx, input cy, output rgb);
endinterface

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: five patterns, button-cycled with frame-start commit.
// Optional build macro PATGEN_CROSSHAIR_EN adds a white centre crosshair overlay.
module video_pattern_gen #(
  parameter int          BIT_WIDTH       = 11,
  parameter int          FRAME_WIDTH     = 1280,
  parameter int          FRAME_HEIGHT    = 720,
  parameter int          DEBOUNCE_CYCLES = 742500,
  parameter logic [23:0] LFSR_SEED       = 24'hACE1F5
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  video_pattern_gen_if.slave  vid,
  input  logic                mode_btn,
  output logic [2:0]          mode,
  output logic [7:0]          frame_count
);

  localparam int                   DB_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]          SEED_EFF = (LFSR_SEED == 24'h000000) ? 24'h000001 : LFSR_SEED;
  localparam int                   BAR_W    = FRAME_WIDTH / 8;
  localparam logic [BIT_WIDTH-1:0] FW       = BIT_WIDTH'(FRAME_WIDTH);
  localparam logic [BIT_WIDTH-1:0] FH       = BIT_WIDTH'(FRAME_HEIGHT);
  localparam logic [BIT_WIDTH-1:0] X_LAST   = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] Y_LAST   = BIT_WIDTH'(FRAME_HEIGHT - 1);

  logic            r_sync1, r_sync2, r_db;
  logic [DB_W-1:0] r_db_cnt;
  logic [2:0]      r_pending, r_mode;
  logic [7:0]      r_frame_count;
  logic [23:0]     r_lfsr, r_rgb;

  logic            w_mismatch, w_db_accept, w_db_rise;
  logic [2:0]      w_pending_next, w_mode_eff;
  logic            w_frame_start, w_frame_end, w_active;
  logic [6:0]      w_bar_ge;
  logic [2:0]      w_bar_idx;
  logic [7:0]      w_grey;
  logic [23:0]     w_pattern, w_rgb_next;

  // Button path: sync, debounce, rising-edge detect feeding the pending mode.
  always_comb begin
    w_mismatch     = r_sync2 ^ r_db;
    w_db_accept    = w_mismatch && (r_db_cnt == DB_LAST);
    w_db_rise      = w_db_accept && r_sync2;
    w_pending_next = r_pending;
    if (w_db_rise)
      w_pending_next = (r_pending == 3'd4) ? 3'd0 : r_pending + 3'd1;
    w_frame_start  = (vid.cx == '0) && (vid.cy == '0);
    w_frame_end    = (vid.cx == X_LAST) && (vid.cy == Y_LAST);
    // Pixel (0,0) already belongs to the newly committed mode.
    w_mode_eff     = w_frame_start ? w_pending_next : r_mode;
  end

  // Thermometer of bar boundaries; the last bar absorbs any remainder.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar
      assign w_bar_ge[gi] = (vid.cx >= BIT_WIDTH'((gi + 1) * BAR_W));
    end
  endgenerate

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 0; k < 7; k++)
      w_bar_idx = w_bar_idx + {2'b00, w_bar_ge[k]};
  end

  always_comb begin
    w_active  = (vid.cx < FW) && (vid.cy < FH);
    w_grey    = vid.cx[7:0] + r_frame_count;
    w_pattern = {{8{~w_bar_idx[1]}}, {8{~w_bar_idx[2]}}, {8{~w_bar_idx[0]}}};
    case (w_mode_eff)
      3'd1:    w_pattern = (vid.cx[5] ^ vid.cy[5]) ? 24'hFFFFFF : 24'h000000;
      3'd2:    w_pattern = {w_grey, w_grey, w_grey};
      3'd3:    w_pattern = r_lfsr;
      3'd4:    w_pattern = {r_frame_count, ~r_frame_count, 8'h80};
      default: ;
    endcase
`ifdef PATGEN_CROSSHAIR_EN
    if ((vid.cx == BIT_WIDTH'(FRAME_WIDTH / 2)) || (vid.cy == BIT_WIDTH'(FRAME_HEIGHT / 2)))
      w_pattern = 24'hFFFFFF;
`else
`endif
    w_rgb_next = w_active ? w_pattern : 24'h000000;
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_db          <= 1'b0;
      r_db_cnt      <= '0;
      r_pending     <= 3'd0;
      r_mode        <= 3'd0;
      r_frame_count <= 8'd0;
      r_lfsr        <= SEED_EFF;
      r_rgb         <= 24'h000000;
    end else begin
      r_sync1 <= mode_btn;
      r_sync2 <= r_sync1;
      if (!w_mismatch || w_db_accept)
        r_db_cnt <= '0;
      else
        r_db_cnt <= r_db_cnt + 1'b1;
      if (w_db_accept)
        r_db <= r_sync2;
      r_pending <= w_pending_next;
      if (w_frame_start)
        r_mode <= w_pending_next;
      if (w_frame_end)
        r_frame_count <= r_frame_count + 8'd1;
      r_lfsr <= {r_lfsr[22:0], r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16]};
      r_rgb  <= w_rgb_next;
    end
  end

  assign vid.rgb     = r_rgb;
  assign mode        = r_mode;
  assign frame_count = r_frame_count;

endmodule
